// File: rtl/soc_timer.sv
`default_nettype none
// ============================================================================
// Module   : soc_timer
// Purpose  : picorv32 MMIO timer: prescaled 32-bit counter, compare match,
//            sticky MATCH/OVF status with IRQ. Optional watchdog under the
//            SOC_TIMER_WDT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module soc_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0100_0020,
    parameter int          PRESCALE_W = 16
) (
    input  logic        r_clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        tmr_hit,
    output logic        tmr_ready,
    output logic [31:0] tmr_rdata,
    output logic        irq,
    output logic        wdt_panic
);
    localparam logic [2:0] c_off_ctrl     = 3'd0;
    localparam logic [2:0] c_off_prescale = 3'd1;
    localparam logic [2:0] c_off_count    = 3'd2;
    localparam logic [2:0] c_off_compare  = 3'd3;
    localparam logic [2:0] c_off_status   = 3'd4;

    logic [3:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_q, irq_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;

`ifdef SOC_TIMER_WDT_EN
    localparam logic [2:0]  c_off_wdt_kick = 3'd5;
    localparam logic [2:0]  c_off_wdt_load = 3'd6;
    localparam logic [31:0] c_wdt_key      = 32'h0000_A5A5;

    logic [31:0] wdt_load_q, wdt_load_d;
    logic [31:0] wdt_cnt_q, wdt_cnt_d;
    logic        wdt_panic_q, wdt_panic_d;
`endif

    logic [2:0]  w_off;
    logic        w_req;
    logic        w_wr;
    logic        w_tick;
    logic [31:0] w_rd_val;
    logic        unused_addr_lsb;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign tmr_hit         = (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_off           = mem_addr[4:2];
    assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};
    // Blocking on ready_q forces the one-idle-cycle gap between transactions.
    assign w_req           = mem_valid & tmr_hit & ~ready_q;
    assign w_wr            = w_req & (|mem_wstrb);
    assign w_tick          = ctrl_q[0] & (pcnt_q == prescale_q);

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            c_off_ctrl:     w_rd_val = {28'd0, ctrl_q};
            c_off_prescale: w_rd_val = 32'(prescale_q);
            c_off_count:    w_rd_val = count_q;
            c_off_compare:  w_rd_val = compare_q;
            c_off_status:   w_rd_val = {30'd0, ovf_q, match_q};
`ifdef SOC_TIMER_WDT_EN
            c_off_wdt_kick: w_rd_val = wdt_cnt_q;
            c_off_wdt_load: w_rd_val = wdt_load_q;
`endif
            default:        w_rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        ovf_d      = ovf_q;

        if (ctrl_q[0]) begin
            pcnt_d = w_tick ? '0 : pcnt_q + 1'b1;
        end

        // W1C is applied before the hardware set below so a coincident set wins.
        if (w_wr) begin
            case (w_off)
                c_off_ctrl: begin
                    if (mem_wstrb[0]) begin
                        ctrl_d[2:0] = mem_wdata[2:0];
`ifdef SOC_TIMER_WDT_EN
                        ctrl_d[3]   = ctrl_q[3] | mem_wdata[3];
`endif
                    end
                end
                c_off_prescale: begin
                    for (int i = 0; i < PRESCALE_W; i++) begin
                        if (mem_wstrb[i/8]) prescale_d[i] = mem_wdata[i];
                    end
                    pcnt_d = '0;
                end
                c_off_count:   count_d   = merge_bytes(count_q, mem_wdata, mem_wstrb);
                c_off_compare: compare_d = merge_bytes(compare_q, mem_wdata, mem_wstrb);
                c_off_status: begin
                    if (mem_wstrb[0] && mem_wdata[0]) match_d = 1'b0;
                    if (mem_wstrb[0] && mem_wdata[1]) ovf_d   = 1'b0;
                end
                default: ;
            endcase
        end

        // A bus write to COUNT overrides the tick entirely.
        if (w_tick && !(w_wr && (w_off == c_off_count))) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;
                count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
            if (count_q == 32'hFFFF_FFFF) ovf_d = 1'b1;
        end

        irq_d   = ctrl_q[2] & (match_q | ovf_q);
        ready_d = w_req;
        rdata_d = w_req ? w_rd_val : 32'd0;
    end

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign tmr_ready = ready_q;
    assign tmr_rdata = rdata_q;
    assign irq       = irq_q;

`ifdef SOC_TIMER_WDT_EN
    always_comb begin
        wdt_load_d  = wdt_load_q;
        wdt_cnt_d   = wdt_cnt_q;
        wdt_panic_d = wdt_panic_q;
        if (w_wr && (w_off == c_off_wdt_load)) begin
            wdt_load_d = merge_bytes(wdt_load_q, mem_wdata, mem_wstrb);
        end
        // Reload on a valid kick or on the 0->1 edge of WDT_EN.
        if ((w_wr && (w_off == c_off_wdt_kick) && (mem_wdata == c_wdt_key)) ||
            (w_wr && (w_off == c_off_ctrl) && mem_wstrb[0] && mem_wdata[3] && !ctrl_q[3])) begin
            wdt_cnt_d = wdt_load_q;
        end else if (ctrl_q[3]) begin
            if (wdt_cnt_q != 32'd0) wdt_cnt_d = wdt_cnt_q - 32'd1;
            if (wdt_cnt_q <= 32'd1) wdt_panic_d = 1'b1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            wdt_load_q  <= '0;
            wdt_cnt_q   <= '0;
            wdt_panic_q <= 1'b0;
        end else begin
            wdt_load_q  <= wdt_load_d;
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_panic_q <= wdt_panic_d;
        end
    end

    assign wdt_panic = wdt_panic_q;
`else
    assign wdt_panic = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_soc_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_timer
// Purpose  : Directed self-checking bench for soc_timer (register table plus
//            multi-cycle timer, overflow, W1C and watchdog sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_timer;
    localparam logic [31:0] c_base = 32'h0100_0020;
    localparam int          NV     = 30;

    typedef struct {
        logic [4:0]  off;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    logic        r_clk     = 1'b0;
    logic        rst_n     = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        tmr_hit;
    logic        tmr_ready;
    logic [31:0] tmr_rdata;
    logic        irq;
    logic        wdt_panic;

    int n_vec = 0;
    int n_err = 0;

    vec_t        tbl [NV];
    logic [31:0] rd;
    logic        rdy;
    logic [31:0] exp_wdt_load;

    soc_timer #(
        .BASE_ADDR (c_base),
        .PRESCALE_W(16)
    ) dut (
        .r_clk    (r_clk),
        .rst_n    (rst_n),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .tmr_hit  (tmr_hit),
        .tmr_ready(tmr_ready),
        .tmr_rdata(tmr_rdata),
        .irq      (irq),
        .wdt_panic(wdt_panic)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request is sampled on the next rising edge; returns on the falling edge after it.
    task automatic bus(input logic [4:0] off, input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic ready);
        @(negedge r_clk);
        mem_valid = 1'b1;
        mem_addr  = c_base + 32'(off);
        mem_wdata = wdata;
        mem_wstrb = strb;
        @(negedge r_clk);
        ready     = tmr_ready;
        rdata     = tmr_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = '0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] d;
        logic        r;
        bus(off, wdata, strb, d, r);
    endtask

    task automatic rd_check(input string name, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        bus(off, 32'd0, 4'h0, d, r);
        check({name, " ready"}, 32'(r), 32'd1);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge r_clk);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef SOC_TIMER_WDT_EN
        exp_wdt_load = 32'h0000_FFFF;
`else
        exp_wdt_load = 32'h0000_0000;
`endif
        for (int i = 0; i < 8; i++) tbl[i] = '{5'(i * 4), 32'h0, 4'h0, 32'h0};
        tbl[8]  = '{5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[9]  = '{5'h04, 32'h0,         4'h0, 32'h0000_FFFF};
        tbl[10] = '{5'h04, 32'h1234_5678, 4'h1, 32'h0};
        tbl[11] = '{5'h04, 32'h0,         4'h0, 32'h0000_FF78};
        tbl[12] = '{5'h0C, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[13] = '{5'h0C, 32'h1100_0000, 4'h8, 32'h0};
        tbl[14] = '{5'h0C, 32'h0,         4'h0, 32'h11AD_BEEF};
        tbl[15] = '{5'h08, 32'h0102_0304, 4'hF, 32'h0};
        tbl[16] = '{5'h08, 32'h0000_00AB, 4'h1, 32'h0};
        tbl[17] = '{5'h08, 32'h0,         4'h0, 32'h0102_03AB};
        tbl[18] = '{5'h00, 32'hFFFF_FFF2, 4'hF, 32'h0};
        tbl[19] = '{5'h00, 32'h0,         4'h0, 32'h0000_0002};
        tbl[20] = '{5'h10, 32'h0000_0003, 4'hF, 32'h0};
        tbl[21] = '{5'h10, 32'h0,         4'h0, 32'h0};
        tbl[22] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[23] = '{5'h1C, 32'h0,         4'h0, 32'h0};
        tbl[24] = '{5'h18, 32'h0000_FFFF, 4'hF, 32'h0};
        tbl[25] = '{5'h18, 32'h0,         4'h0, exp_wdt_load};
        tbl[26] = '{5'h14, 32'h0,         4'h0, 32'h0};
        tbl[27] = '{5'h00, 32'h0,         4'hF, 32'h0};
        tbl[28] = '{5'h00, 32'h0,         4'h0, 32'h0};
        tbl[29] = '{5'h0F, 32'h0,         4'h0, 32'h11AD_BEEF};

        repeat (3) @(negedge r_clk);
        check("reset ready", 32'(tmr_ready), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        check("reset panic", 32'(wdt_panic), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus(tbl[i].off, tbl[i].wdata, tbl[i].wstrb, rd, rdy);
            check($sformatf("v%0d ready", i), 32'(rdy), 32'd1);
            if (tbl[i].wstrb == 4'h0) check($sformatf("v%0d rdata", i), rd, tbl[i].exp);
            @(negedge r_clk);
            check($sformatf("v%0d ready drop", i), 32'(tmr_ready), 32'd0);
        end

        // Compare match, no auto-reload: ticks every 4 clocks, match on 6th.
        do_reset();
        wr(5'h04, 32'd3, 4'hF);
        wr(5'h0C, 32'd5, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        repeat (24) @(negedge r_clk);
        check("match irq early", 32'(irq), 32'd0);
        @(negedge r_clk);
        check("match irq", 32'(irq), 32'd1);
        rd_check("match count", 5'h08, 32'd6);
        rd_check("match status", 5'h10, 32'd1);

        // Auto-reload, W1C clearing irq, W1C colliding with a match.
        do_reset();
        wr(5'h04, 32'd3, 4'hF);
        wr(5'h0C, 32'd5, 4'hF);
        wr(5'h00, 32'h7, 4'hF);
        repeat (25) @(negedge r_clk);
        check("ar irq", 32'(irq), 32'd1);
        rd_check("ar count reload", 5'h08, 32'd0);
        wr(5'h10, 32'h1, 4'hF);
        check("ar irq before clear", 32'(irq), 32'd1);
        @(negedge r_clk);
        check("ar irq cleared", 32'(irq), 32'd0);
        repeat (16) @(negedge r_clk);
        wr(5'h10, 32'h1, 4'hF);
        rd_check("ar w1c vs set", 5'h10, 32'd1);
        check("ar irq after collide", 32'(irq), 32'd1);

        // Overflow with PRESCALE=0, then a byte-strobed COUNT write.
        do_reset();
        wr(5'h08, 32'hFFFF_FFFE, 4'hF);
        wr(5'h00, 32'h1, 4'hF);
        wr(5'h00, 32'h0, 4'hF);
        rd_check("ovf count", 5'h08, 32'd0);
        rd_check("ovf status", 5'h10, 32'd2);
        check("ovf irq gated", 32'(irq), 32'd0);
        wr(5'h08, 32'h0000_00AB, 4'h1);
        rd_check("ovf byte write", 5'h08, 32'h0000_00AB);

        // Bus write to COUNT in a tick cycle suppresses the compare.
        do_reset();
        wr(5'h04, 32'd3, 4'hF);
        wr(5'h00, 32'h1, 4'hF);
        repeat (2) @(negedge r_clk);
        wr(5'h08, 32'h100, 4'hF);
        rd_check("tick write count", 5'h08, 32'h100);
        rd_check("tick write no match", 5'h10, 32'd0);

        // Out-of-window address, then in-window hit.
        @(negedge r_clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0100_0040;
        #1 check("miss hit", 32'(tmr_hit), 32'd0);
        @(negedge r_clk);
        check("miss ready", 32'(tmr_ready), 32'd0);
        mem_addr = 32'h0100_003C;
        #1 check("window top hit", 32'(tmr_hit), 32'd1);
        @(negedge r_clk);
        check("window top ready", 32'(tmr_ready), 32'd1);
        mem_valid = 1'b0;

        // Reset arriving with a pending request drops it.
        @(negedge r_clk);
        mem_valid = 1'b1;
        mem_addr  = c_base;
        rst_n     = 1'b0;
        @(negedge r_clk);
        check("reset drops req", 32'(tmr_ready), 32'd0);
        mem_valid = 1'b0;
        rst_n     = 1'b1;

`ifdef SOC_TIMER_WDT_EN
        do_reset();
        wr(5'h18, 32'd10, 4'hF);
        wr(5'h00, 32'h8, 4'hF);
        repeat (9) @(negedge r_clk);
        check("wdt panic early", 32'(wdt_panic), 32'd0);
        @(negedge r_clk);
        check("wdt panic", 32'(wdt_panic), 32'd1);
        wr(5'h00, 32'h0, 4'hF);
        rd_check("wdt en sticky", 5'h00, 32'h8);

        do_reset();
        wr(5'h18, 32'd10, 4'hF);
        wr(5'h00, 32'h8, 4'hF);
        repeat (3) @(negedge r_clk);
        wr(5'h14, 32'h0000_A5A5, 4'hF);
        repeat (9) @(negedge r_clk);
        check("wdt kick early", 32'(wdt_panic), 32'd0);
        @(negedge r_clk);
        check("wdt kick panic", 32'(wdt_panic), 32'd1);

        do_reset();
        wr(5'h18, 32'd10, 4'hF);
        wr(5'h00, 32'h8, 4'hF);
        wr(5'h14, 32'h0000_1234, 4'hF);
        repeat (7) @(negedge r_clk);
        check("wdt bad key early", 32'(wdt_panic), 32'd0);
        @(negedge r_clk);
        check("wdt bad key panic", 32'(wdt_panic), 32'd1);
`else
        do_reset();
        wr(5'h00, 32'h8, 4'hF);
        rd_check("no wdt ctrl3", 5'h00, 32'h0);
        repeat (20) @(negedge r_clk);
        check("no wdt panic", 32'(wdt_panic), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
